vc_stream_eq_checker: RTL and testbench
=======================================

Name: vc_stream_eq_checker

Overview:
- Sequential consumer of equality-comparator results: joins an expected-value stream and an actual-value stream over val/rdy handshakes.
- Compares each pair for equality and tallies mismatches over a programmed item count.
- Captures the first mismatching pair and reports done/pass.
- Sits downstream of the 32-bit EQ comparator in the FFT accelerator test and self-check paths, e.g. golden vs DUT output streams.

Parameters:
W, 32, width of compared messages
CNT_W, 16, width of item and error counters

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a check run (honoured in IDLE or DONE only)
num_items  input  CNT_W  items to check; sampled when start is honoured
exp_msg  input  W  expected value
exp_val  input  1  expected value valid
exp_rdy  output  1  checker accepts expected value
act_msg  input  W  actual value
act_val  input  1  actual value valid
act_rdy  output  1  checker accepts actual value
match_val  output  1  one-cycle pulse: match holds result of a compared pair
match  output  1  1 if last compared pair was equal
done  output  1  high while in DONE
pass  output  1  high in DONE when err_count == 0; 0 otherwise
err_count  output  CNT_W  mismatches this run, saturating
first_err_val  output  1  a mismatch has been captured this run
first_err_idx  output  CNT_W  item index (0-based) of first mismatch
first_err_exp  output  W  exp_msg of first mismatch
first_err_act  output  W  act_msg of first mismatch

Behaviour:
- Clock is clk. Reset is synchronous and active-high (reset).
- Reset: state = IDLE. All outputs are 0, including rdys, match_val, done, pass, counters and capture registers. Reset has priority over every other event, including mid-RUN; partially checked state is discarded.
- States:
  - IDLE: rdys 0. start -> latch num_items, clear item_cnt, err_count, first_err_*. Go to RUN, or directly to DONE if num_items == 0.
  - RUN: exp_rdy = act_val, act_rdy = exp_val. Each rdy depends only on the opposite val, so there is no combinational loop.
    - fire = exp_val & act_val. Both streams transfer on the same edge; a lone valid never transfers.
    - On fire:
      - match <= (exp_msg == act_msg); match_val pulses high the next cycle.
      - item_cnt increments.
      - On mismatch, err_count increments, saturating at all-ones (no wrap).
      - On mismatch with first_err_val == 0, capture idx = item_cnt (pre-increment), exp_msg, act_msg, and set first_err_val.
    - When fire occurs with item_cnt == latched num_items - 1, go to DONE.
    - start in RUN is ignored.
  - DONE: rdys 0; done = 1; pass = (err_count == 0).
    - Results hold until start or reset.
    - start in DONE behaves as in IDLE: clear results and rerun.
- Latency:
  - match_val, err_count and first_err_* update at the edge ending the fire cycle.
  - done rises in the same cycle as the final match_val.
  - Throughput is one pair per cycle.
- match holds its last value between pulses.
- match_val is 0 outside the cycle following a fire.
- num_items = all-ones is legal; item_cnt must not overflow before the final item.
- Extra items presented in IDLE or DONE are not accepted (rdy 0).

Test Plan:
1. start, num_items=4; 4 equal pairs (deadbeef, de3456ef, ...) with both vals held high -> 4 consecutive match_val pulses with match=1; done on the 4th; pass=1; err_count=0; first_err_val=0.
2. num_items=4; pair 2 = deadbeef/deadbeee, pair 3 = dea1492e/12fda567 -> err_count=2; first_err_idx=2; first_err_exp=deadbeef; first_err_act=deadbeee; pass=0.
3. Backpressure: act_val low for 3 cycles while exp_val is high -> exp_rdy=0 and no fire or match_val in those cycles. Transfers resume when both are valid; final counts are identical to the unstalled run.
4. num_items=0 -> DONE on the cycle after start; pass=1; no rdy ever asserted.
5. reset asserted after 2 of 4 items -> next cycle IDLE; all outputs 0; a subsequent start with 1 equal pair -> done, pass=1.
6. start pulsed during RUN -> ignored, counts continue. start in DONE after a failing run -> err_count and first_err_val cleared; a new 2-item clean run ends with pass=1.

Source files
------------

// File: rtl/vc_stream_eq_checker.sv
// Stream equality checker: joins an expected-value stream and an actual-value
// stream, compares each transferred pair, tallies mismatches over a programmed
// item count and captures the first mismatching pair for post-run inspection.
module vc_stream_eq_checker #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_items,
  input  logic [W-1:0]     exp_msg,
  input  logic             exp_val,
  output logic             exp_rdy,
  input  logic [W-1:0]     act_msg,
  input  logic             act_val,
  output logic             act_rdy,
  output logic             match_val,
  output logic             match,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_val,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [W-1:0]     first_err_exp,
  output logic [W-1:0]     first_err_act
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] item_cnt;
  logic             fire;
  logic             start_ok;
  logic             last_item;
  logic             pair_eq;

  // Error tally sticks at all-ones instead of wrapping back to a clean count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Final item is the one transferring while the count sits at num_items-1;
  // comparing before the increment keeps an all-ones num_items from overflowing.
  assign last_item = (item_cnt == num_lat - CNT_W'(1));
  assign pair_eq   = (exp_msg == act_msg);

  // Next-state, handshake and status decode; each rdy follows only the
  // opposite valid so a pair transfers on one edge and no comb loop forms.
  always_comb begin
    state_nxt = state;
    exp_rdy   = 1'b0;
    act_rdy   = 1'b0;
    fire      = 1'b0;
    start_ok  = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = (num_items == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        exp_rdy = act_val;
        act_rdy = exp_val;
        fire    = exp_val & act_val;
        if (fire && last_item) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = (num_items == '0) ? DONE : RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset discards any run in progress.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Run bookkeeping: clear on an honoured start, tally and capture on each transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_lat       <= '0;
      item_cnt      <= '0;
      err_count     <= '0;
      first_err_val <= 1'b0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      match         <= 1'b0;
      match_val     <= 1'b0;
    end else begin
      match_val <= fire;
      if (start_ok) begin
        num_lat       <= num_items;
        item_cnt      <= '0;
        err_count     <= '0;
        first_err_val <= 1'b0;
        first_err_idx <= '0;
        first_err_exp <= '0;
        first_err_act <= '0;
      end else if (fire) begin
        match    <= pair_eq;
        item_cnt <= item_cnt + CNT_W'(1);
        if (!pair_eq) begin
          err_count <= sat_inc(err_count);
          if (!first_err_val) begin
            first_err_val <= 1'b1;
            first_err_idx <= item_cnt;
            first_err_exp <= exp_msg;
            first_err_act <= act_msg;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vc_stream_eq_checker.sv
// Testbench for vc_stream_eq_checker: a driver issues pair streams and pushes
// the expected per-pair result into a scoreboard; a monitor pops on match_val.
module tb_vc_stream_eq_checker;
  localparam int W     = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_items;
  logic [W-1:0]     exp_msg;
  logic             exp_val;
  logic             exp_rdy;
  logic [W-1:0]     act_msg;
  logic             act_val;
  logic             act_rdy;
  logic             match_val;
  logic             match;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic             first_err_val;
  logic [CNT_W-1:0] first_err_idx;
  logic [W-1:0]     first_err_exp;
  logic [W-1:0]     first_err_act;

  vc_stream_eq_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_items(num_items),
    .exp_msg(exp_msg), .exp_val(exp_val), .exp_rdy(exp_rdy),
    .act_msg(act_msg), .act_val(act_val), .act_rdy(act_rdy),
    .match_val(match_val), .match(match), .done(done), .pass(pass),
    .err_count(err_count), .first_err_val(first_err_val),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic m;
    logic last;
  } sb_t;

  sb_t          sbq[$];
  logic [W-1:0] ie[$];
  logic [W-1:0] ia[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, req, $time);
    end
  endtask

  // Monitor: every match_val pulse must correspond to a pair the driver transferred.
  always @(negedge clk) begin
    sb_t e;
    if (match_val === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_match_val", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("match", {63'd0, match}, {63'd0, e.m});
        chk("done_with_final_pulse", {63'd0, done}, {63'd0, e.last});
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_exp_rdy"}, {63'd0, exp_rdy}, 64'd0);
    chk({tag, "_act_rdy"}, {63'd0, act_rdy}, 64'd0);
    chk({tag, "_match_val"}, {63'd0, match_val}, 64'd0);
    chk({tag, "_match"}, {63'd0, match}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'd0);
    chk({tag, "_first_err_val"}, {63'd0, first_err_val}, 64'd0);
    chk({tag, "_first_err_idx"}, 64'(first_err_idx), 64'd0);
    chk({tag, "_first_err_exp"}, 64'(first_err_exp), 64'd0);
    chk({tag, "_first_err_act"}, 64'(first_err_act), 64'd0);
  endtask

  // mode 0: both valids held high; 1: random valids; 2: act stalls 3 cycles
  // before item 1 while exp stays valid. abort_at >= 0 resets the DUT once that
  // many items have transferred.
  task automatic do_run(input int n, input int mode, input bit mid_start, input int abort_at);
    int           errs;
    int           fidx;
    logic [W-1:0] fe;
    logic [W-1:0] fa;
    bit           fired;
    int           tries;
    sb_t          x;
    errs = 0; fidx = -1; fe = '0; fa = '0;
    for (int i = 0; i < n; i++) begin
      if (ie[i] != ia[i]) begin
        errs++;
        if (fidx < 0) begin
          fidx = i; fe = ie[i]; fa = ia[i];
        end
      end
    end

    @(posedge clk); #1;
    start = 1'b1; num_items = CNT_W'(n); exp_val = 1'b0; act_val = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_done", {63'd0, done}, {63'd0, (n == 0)});
    chk("start_err_count_clear", 64'(err_count), 64'd0);
    chk("start_first_err_clear", {63'd0, first_err_val}, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < n; i++) begin
      if (i == abort_at) break;
      exp_msg = ie[i]; act_msg = ia[i];
      fired = 1'b0; tries = 0;
      while (!fired) begin
        case (mode)
          0: begin exp_val = 1'b1; act_val = 1'b1; end
          1: begin
            if (tries >= 6) begin exp_val = 1'b1; act_val = 1'b1; end
            else begin
              exp_val = ($urandom_range(0, 3) != 0);
              act_val = ($urandom_range(0, 3) != 0);
            end
          end
          default: begin
            exp_val = 1'b1;
            act_val = !(i == 1 && tries < 3);
          end
        endcase
        start = mid_start && (i == 1) && (tries == 0);
        if (exp_val && act_val) begin
          x.m = (ie[i] == ia[i]); x.last = (i == n - 1);
          sbq.push_back(x);
        end
        @(negedge clk);
        chk("run_exp_rdy", {63'd0, exp_rdy}, {63'd0, act_val});
        chk("run_act_rdy", {63'd0, act_rdy}, {63'd0, exp_val});
        @(posedge clk); #1;
        start = 1'b0;
        fired = exp_val && act_val;
        tries++;
      end
    end
    exp_val = 1'b0; act_val = 1'b0;

    if (abort_at >= 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; exp_val = 1'b1; act_val = 1'b1;
      @(negedge clk);
      chk_all_zero("after_abort");
      @(posedge clk); #1;
      exp_val = 1'b0; act_val = 1'b0;
      @(negedge clk);
      chk("abort_sb_drained", 64'(sbq.size()), 64'd0);
      return;
    end

    @(negedge clk);
    chk("final_done", {63'd0, done}, 64'd1);
    chk("final_pass", {63'd0, pass}, {63'd0, (errs == 0)});
    chk("final_err_count", 64'(err_count), 64'(errs));
    chk("final_first_err_val", {63'd0, first_err_val}, {63'd0, (fidx >= 0)});
    chk("final_first_err_idx", 64'(first_err_idx), (fidx >= 0) ? 64'(fidx) : 64'd0);
    chk("final_first_err_exp", 64'(first_err_exp), 64'(fe));
    chk("final_first_err_act", 64'(first_err_act), 64'(fa));
    // Offer more data in DONE: nothing must be accepted and results must hold.
    @(posedge clk); #1;
    exp_val = 1'b1; act_val = 1'b1;
    @(negedge clk);
    chk("done_exp_rdy", {63'd0, exp_rdy}, 64'd0);
    chk("done_act_rdy", {63'd0, act_rdy}, 64'd0);
    @(posedge clk); #1;
    exp_val = 1'b0; act_val = 1'b0;
    @(negedge clk);
    chk("hold_done", {63'd0, done}, 64'd1);
    chk("hold_err_count", 64'(err_count), 64'(errs));
    if (n > 0) chk("hold_match", {63'd0, match}, {63'd0, (ie[n-1] == ia[n-1])});
    chk("sb_drained", 64'(sbq.size()), 64'd0);
  endtask

  task automatic load_pairs(input int n, input int eq_pct);
    logic [W-1:0] e;
    logic [W-1:0] flip;
    ie.delete(); ia.delete();
    for (int i = 0; i < n; i++) begin
      e = $urandom();
      ie.push_back(e);
      if ($urandom_range(0, 99) < eq_pct) ia.push_back(e);
      else begin
        flip = $urandom();
        if (flip == '0) flip = 32'h1;
        ia.push_back(e ^ flip);
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_items = '0;
    exp_msg = '0; act_msg = '0; exp_val = 1'b0; act_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_val = 1'b1; act_val = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_exp_rdy", {63'd0, exp_rdy}, 64'd0);
    chk("idle_act_rdy", {63'd0, act_rdy}, 64'd0);
    exp_val = 1'b0; act_val = 1'b0;

    // Four equal pairs, streaming back to back.
    ie = '{32'hdeadbeef, 32'hde3456ef, 32'h12345678, 32'ha5a5a5a5};
    ia = '{32'hdeadbeef, 32'hde3456ef, 32'h12345678, 32'ha5a5a5a5};
    do_run(4, 0, 1'b0, -1);

    // Two mismatches, first at index 2.
    ie = '{32'h00000001, 32'hcafef00d, 32'hdeadbeef, 32'hdea1492e};
    ia = '{32'h00000001, 32'hcafef00d, 32'hdeadbeee, 32'h12fda567};
    do_run(4, 0, 1'b0, -1);
    // Same data with act stalled for three cycles.
    do_run(4, 2, 1'b0, -1);
    // Same failing data with start pulsed mid-run.
    do_run(4, 0, 1'b1, -1);
    // Start from a failing DONE: clean two-item rerun.
    ie = '{32'h0badf00d, 32'h600df00d};
    ia = '{32'h0badf00d, 32'h600df00d};
    do_run(2, 1, 1'b0, -1);

    // Zero items goes straight to DONE with pass.
    do_run(0, 0, 1'b0, -1);

    // Reset after two of four items, then a single clean item.
    ie = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    ia = '{32'h11111111, 32'h22222223, 32'h33333333, 32'h44444444};
    do_run(4, 0, 1'b0, 2);
    ie = '{32'h13572468};
    ia = '{32'h13572468};
    do_run(1, 0, 1'b0, -1);

    // Randomized runs with random valid patterns.
    for (int r = 0; r < 12; r++) begin
      load_pairs($urandom_range(1, 20), (r % 3 == 0) ? 100 : 60);
      do_run(ie.size(), 1, (r % 4 == 1) && (ie.size() >= 2), -1);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
